// File: rtl/traffic_generator_burst_scheduler.sv
// Frame launch pacer for the GMII traffic generator: turns burst, gap and total-frame
// settings into a per-frame request/acknowledge handshake and keeps frame/burst counts.
module traffic_generator_burst_scheduler #(
  parameter int unsigned C_CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [C_CNT_WIDTH-1:0] frames_per_burst,
  input  logic [C_CNT_WIDTH-1:0] interburst_gap,
  input  logic [C_CNT_WIDTH-1:0] total_frames,
  output logic                   frame_req,
  input  logic                   frame_ack,
  input  logic                   frame_done,
  output logic                   busy,
  output logic                   done,
  output logic [C_CNT_WIDTH-1:0] frames_sent,
  output logic [C_CNT_WIDTH-1:0] bursts_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DONE,
    S_BURST_GAP,
    S_FINISHED
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] ONE = C_CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] fpb_q, fpb_d;
  logic [C_CNT_WIDTH-1:0] gap_q, gap_d;
  logic [C_CNT_WIDTH-1:0] total_q, total_d;
  logic [C_CNT_WIDTH-1:0] frames_q, frames_d;
  logic [C_CNT_WIDTH-1:0] bursts_q, bursts_d;
  logic [C_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [C_CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [C_CNT_WIDTH-1:0] frames_inc;
  logic [C_CNT_WIDTH-1:0] burst_inc;
  logic                   burst_hit;
  logic                   total_hit;

  assign frames_inc = frames_q + ONE;
  assign burst_inc  = burst_cnt_q + ONE;
  assign burst_hit  = (fpb_q != '0) && (burst_inc == fpb_q);
  assign total_hit  = (total_q != '0) && (frames_inc == total_q);

  always_comb begin
    state_d     = state_q;
    fpb_d       = fpb_q;
    gap_d       = gap_q;
    total_d     = total_q;
    frames_d    = frames_q;
    bursts_d    = bursts_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          fpb_d       = frames_per_burst;
          gap_d       = interburst_gap;
          total_d     = total_frames;
          frames_d    = '0;
          bursts_d    = '0;
          burst_cnt_d = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (frame_ack)   state_d = S_WAIT_DONE;
        else if (!enable) state_d = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (frame_done) begin
          frames_d    = frames_inc;
          burst_cnt_d = burst_inc;
          // Completion wins over enable drop; a burst closing on the last frame still counts.
          if (total_hit) begin
            if (burst_hit) begin
              bursts_d    = bursts_q + ONE;
              burst_cnt_d = '0;
            end
            state_d = S_FINISHED;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else if (burst_hit) begin
            bursts_d    = bursts_q + ONE;
            burst_cnt_d = '0;
            if (gap_q == '0) begin
              state_d = S_REQ;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = S_BURST_GAP;
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_BURST_GAP: begin
        gap_cnt_d = gap_cnt_q - ONE;
        if (!enable)              state_d = S_IDLE;
        else if (gap_cnt_q == ONE) state_d = S_REQ;
      end
      S_FINISHED: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_REQ);
    busy_d = (state_d == S_REQ) || (state_d == S_WAIT_DONE) || (state_d == S_BURST_GAP);
    done_d = (state_d == S_FINISHED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      fpb_q       <= '0;
      gap_q       <= '0;
      total_q     <= '0;
      frames_q    <= '0;
      bursts_q    <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpb_q       <= fpb_d;
      gap_q       <= gap_d;
      total_q     <= total_d;
      frames_q    <= frames_d;
      bursts_q    <= bursts_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign frame_req   = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;
  assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_traffic_generator_burst_scheduler.sv
// Directed bench for traffic_generator_burst_scheduler: burst pacing, totals, enable drops, reset.
module tb_traffic_generator_burst_scheduler;

  localparam int unsigned W = 32;

  logic         clk;
  logic         resetn;
  logic         enable;
  logic [W-1:0] frames_per_burst;
  logic [W-1:0] interburst_gap;
  logic [W-1:0] total_frames;
  logic         frame_req;
  logic         frame_ack;
  logic         frame_done;
  logic         busy;
  logic         done;
  logic [W-1:0] frames_sent;
  logic [W-1:0] bursts_sent;

  int pass_cnt;
  int total_cnt;

  traffic_generator_burst_scheduler #(.C_CNT_WIDTH(W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .frames_per_burst (frames_per_burst),
    .interburst_gap   (interburst_gap),
    .total_frames     (total_frames),
    .frame_req        (frame_req),
    .frame_ack        (frame_ack),
    .frame_done       (frame_done),
    .busy             (busy),
    .done             (done),
    .frames_sent      (frames_sent),
    .bursts_sent      (bursts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack the pending request, finish the frame 5 cycles later, then count cycles until the next request.
  task automatic do_frame(input int wait_limit, output int n);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    total_cnt++;
    if (frame_req !== 1'b0) $display("FAIL req_drop_after_ack: got %0b expected 0", frame_req);
    else pass_cnt++;
    repeat (4) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    n = 0;
    while (frame_req !== 1'b1 && n < wait_limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; frame_ack = 1'b0; frame_done = 1'b0;
    frames_per_burst = '0; interburst_gap = '0; total_frames = '0;
    #3;
    total_cnt++;
    if ({frame_req, busy, done} !== 3'b000) $display("FAIL reset_flags: got %03b expected 000", {frame_req, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (frames_sent !== 0 || bursts_sent !== 0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", frames_sent, bursts_sent);
    else pass_cnt++;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_burst_gap();
    int n;
    int exp_wait [6] = '{0, 0, 10, 0, 0, 10};
    frames_per_burst = 3; interburst_gap = 10; total_frames = 0;
    enable = 1'b1;
    tick();
    total_cnt++;
    if (frame_req !== 1'b1 || busy !== 1'b1) $display("FAIL burst_first_req: got req=%0b busy=%0b expected 1/1", frame_req, busy);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      do_frame(20, n);
      total_cnt++;
      if (n !== exp_wait[i]) $display("FAIL burst_req_wait[%0d]: got %0d expected %0d", i, n, exp_wait[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frames_sent !== 6 || bursts_sent !== 2) $display("FAIL burst_counts: got %0d/%0d expected 6/2", frames_sent, bursts_sent);
    else pass_cnt++;
    enable = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || frame_req !== 1'b0) $display("FAIL burst_stop: got busy=%0b req=%0b expected 0/0", busy, frame_req);
    else pass_cnt++;
  endtask

  task automatic test_continuous_total();
    int n;
    frames_per_burst = 0; interburst_gap = 0; total_frames = 5;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_frame(10, n);
      total_cnt++;
      if (n !== 0) $display("FAIL cont_req_wait[%0d]: got %0d expected 0", i, n);
      else pass_cnt++;
    end
    do_frame(5, n);
    total_cnt++;
    if (n !== 5) $display("FAIL cont_no_req_after_total: got %0d expected 5", n);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL cont_done: got done=%0b busy=%0b expected 1/0", done, busy);
    else pass_cnt++;
    total_cnt++;
    if (frames_sent !== 5 || bursts_sent !== 0) $display("FAIL cont_counts: got %0d/%0d expected 5/0", frames_sent, bursts_sent);
    else pass_cnt++;
    enable = 1'b0;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL cont_done_clear: got %0b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    frames_per_burst = 2; interburst_gap = 0; total_frames = 4;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      do_frame(10, n);
      total_cnt++;
      if (n !== 0) $display("FAIL b2b_req_wait[%0d]: got %0d expected 0", i, n);
      else pass_cnt++;
      if (i == 1) begin
        total_cnt++;
        if (bursts_sent !== 1) $display("FAIL b2b_mid_bursts: got %0d expected 1", bursts_sent);
        else pass_cnt++;
      end
    end
    do_frame(2, n);
    total_cnt++;
    if (frames_sent !== 4 || bursts_sent !== 2 || done !== 1'b1)
      $display("FAIL b2b_final: got frames=%0d bursts=%0d done=%0b expected 4/2/1", frames_sent, bursts_sent, done);
    else pass_cnt++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop_wait();
    int n;
    frames_per_burst = 0; interburst_gap = 0; total_frames = 0;
    enable = 1'b1;
    tick();
    do_frame(10, n);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    enable = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if (frame_req !== 1'b0 || busy !== 1'b1) $display("FAIL drop_wait_hold: got req=%0b busy=%0b expected 0/1", frame_req, busy);
    else pass_cnt++;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    total_cnt++;
    if (frames_sent !== 2 || busy !== 1'b0 || frame_req !== 1'b0)
      $display("FAIL drop_wait_idle: got frames=%0d busy=%0b req=%0b expected 2/0/0", frames_sent, busy, frame_req);
    else pass_cnt++;
    enable = 1'b1;
    tick();
    total_cnt++;
    if (frames_sent !== 0 || frame_req !== 1'b1) $display("FAIL reenable: got frames=%0d req=%0b expected 0/1", frames_sent, frame_req);
    else pass_cnt++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_gap_drop_and_reset();
    int n;
    frames_per_burst = 1; interburst_gap = 100; total_frames = 0;
    enable = 1'b1;
    tick();
    do_frame(3, n);
    total_cnt++;
    if (n !== 3 || busy !== 1'b1) $display("FAIL gap_in_progress: got wait=%0d busy=%0b expected 3/1", n, busy);
    else pass_cnt++;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    total_cnt++;
    if (frames_sent !== 1) $display("FAIL gap_spurious_done: got %0d expected 1", frames_sent);
    else pass_cnt++;
    enable = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || frame_req !== 1'b0) $display("FAIL gap_drop: got busy=%0b req=%0b expected 0/0", busy, frame_req);
    else pass_cnt++;
    enable = 1'b1;
    tick();
    total_cnt++;
    if (frame_req !== 1'b1) $display("FAIL prereset_req: got %0b expected 1", frame_req);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if (frame_req !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset: got req=%0b busy=%0b expected 0/0", frame_req, busy);
    else pass_cnt++;
    enable = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_config_latch();
    int n;
    frames_per_burst = 0; interburst_gap = 0; total_frames = 3;
    enable = 1'b1;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    total_cnt++;
    if (frames_sent !== 0 || frame_req !== 1'b1) $display("FAIL req_spurious_done: got frames=%0d req=%0b expected 0/1", frames_sent, frame_req);
    else pass_cnt++;
    total_frames = 10;
    do_frame(10, n);
    do_frame(10, n);
    do_frame(3, n);
    total_cnt++;
    if (done !== 1'b1 || frames_sent !== 3) $display("FAIL latched_total: got done=%0b frames=%0d expected 1/3", done, frames_sent);
    else pass_cnt++;
    enable = 1'b0;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_burst_gap();
    test_continuous_total();
    test_back_to_back();
    test_enable_drop_wait();
    test_gap_drop_and_reset();
    test_config_latch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
